mem_arbiter: RTL and testbench

- Shares the single-port instruction/data memory between two requesters: port 0 (CPU core) and port 1 (loader/debug/DMA master).
- Fully registered FSM:
  - latches one request per transaction;
  - drives the memory for exactly one issue cycle;
  - waits the memory's fixed read latency;
  - returns read data to the owner.
- Round-robin fairness on ties; one transaction in flight at a time.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between port 0 (core) and port 1 (loader/DMA).
// One transaction in flight: write = IDLE+ISSUE, read = IDLE+ISSUE+RD_LATENCY waits+RESP; a losing requester holds req.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_r_enable,
   output logic              mem_w_enable,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam int               CNT_W    = 3;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic              r_owner;
   logic              r_last_owner;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic              w_take;
   logic              w_win;
   logic              w_capture;

   // On a tie the port that did not own the previous transaction wins.
   always_comb begin
      w_take = 1'b0;
      w_win  = 1'b0;
      if (r_state == S_IDLE) begin
         if (m0_req && m1_req) begin
            w_take = 1'b1;
            w_win  = ~r_last_owner;
         end else if (m0_req || m1_req) begin
            w_take = 1'b1;
            w_win  = m1_req;
         end
      end
   end

   assign w_capture = (r_state == S_WAIT) && (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      m0_gnt       = 1'b0;
      m1_gnt       = 1'b0;
      m0_rvalid    = 1'b0;
      m1_rvalid    = 1'b0;
      mem_r_enable = 1'b0;
      mem_w_enable = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_take) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_r_enable = ~r_we;
            mem_w_enable = r_we;
            m0_gnt       = ~r_owner;
            m1_gnt       = r_owner;
            w_state_nxt  = r_we ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (w_capture) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            m0_rvalid   = ~r_owner;
            m1_rvalid   = r_owner;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Request latch, latency counter and per-port read data; last_owner starts at 1 so port 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
      end else begin
         if (w_take) begin
            r_we         <= w_win ? m1_we    : m0_we;
            r_addr       <= w_win ? m1_addr  : m0_addr;
            r_wdata      <= w_win ? m1_wdata : m0_wdata;
            r_owner      <= w_win;
            r_last_owner <= w_win;
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= CNT_INIT;
         end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_capture) begin
            if (r_owner) begin
               r_rdata1 <= mem_rdata;
            end else begin
               r_rdata0 <= mem_rdata;
            end
         end
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign m0_rdata  = r_rdata0;
   assign m1_rdata  = r_rdata1;
   assign busy      = (r_state != S_IDLE);
   assign owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter at RD_LATENCY 1 and 3 against a transaction-timing reference model.
module tb_mem_arbiter;

   localparam int N = 2;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset_n   [N];
   logic        req       [N][2];
   logic        we        [N][2];
   logic [31:0] addr      [N][2];
   logic [31:0] wdata     [N][2];
   logic        gnt       [N][2];
   logic        rvalid    [N][2];
   logic [31:0] rdata     [N][2];
   logic [31:0] mem_addr  [N];
   logic        mem_r_enable [N];
   logic        mem_w_enable [N];
   logic [31:0] mem_wdata [N];
   logic [31:0] mem_rdata [N];
   logic        busy      [N];
   logic        owner     [N];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(gi == 0 ? 1 : 3)) u_dut (
         .clk          (clk),
         .reset_n      (reset_n[gi]),
         .m0_req       (req[gi][0]),
         .m0_we        (we[gi][0]),
         .m0_addr      (addr[gi][0]),
         .m0_wdata     (wdata[gi][0]),
         .m0_gnt       (gnt[gi][0]),
         .m0_rvalid    (rvalid[gi][0]),
         .m0_rdata     (rdata[gi][0]),
         .m1_req       (req[gi][1]),
         .m1_we        (we[gi][1]),
         .m1_addr      (addr[gi][1]),
         .m1_wdata     (wdata[gi][1]),
         .m1_gnt       (gnt[gi][1]),
         .m1_rvalid    (rvalid[gi][1]),
         .m1_rdata     (rdata[gi][1]),
         .mem_addr     (mem_addr[gi]),
         .mem_r_enable (mem_r_enable[gi]),
         .mem_w_enable (mem_w_enable[gi]),
         .mem_wdata    (mem_wdata[gi]),
         .mem_rdata    (mem_rdata[gi]),
         .busy         (busy[gi]),
         .owner        (owner[gi])
      );
   end

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int rate   = 100;

   // memory environment
   logic [31:0] rmem [N][16];
   int          ret_cyc [N];
   logic [31:0] ret_dat [N];

   // requesters
   txn_t txq [2*N][$];
   bit   active [N][2];
   bit   gprev  [N][2];
   int   rst_cnt [N];
   bit   rst_arm [N];

   // reference model
   logic [31:0] mmem [N][16];
   int          m_issue [N];
   int          m_resp  [N];
   int          m_free  [N];
   int          m_busy_from [N];
   int          m_reset [N];
   logic        m_last  [N];
   logic        m_port  [N];
   logic        m_we    [N];
   logic [31:0] m_addr  [N];
   logic [31:0] m_wdata [N];
   logic [31:0] m_rdat  [N];
   logic        exp_owner [N];
   logic [31:0] exp_rdata [N][2];
   bit          chk_en [N];

   bit   in_cont = 1'b0;
   bit   have_prev [N];
   logic prev_port [N];
   int   prev_cyc  [N];
   int   n_cont    [N];

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] b(input logic x);
      return {31'd0, x};
   endfunction

   task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s [lat=%0d] cyc=%0d got=%h exp=%h", tag, lat_of(inst), cyc, got, exp);
      end
   endtask

   task automatic push(input int i, input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
      txn_t t;
      t.we    = w;
      t.addr  = a;
      t.wdata = d;
      txq[i*2+p].push_back(t);
   endtask

   task automatic check_outputs(input int i);
      if (cyc == m_reset[i]) begin
         chk_en[i]       = 1'b1;
         exp_rdata[i][0] = '0;
         exp_rdata[i][1] = '0;
         exp_owner[i]    = 1'b0;
      end
      if (cyc == m_issue[i]) exp_owner[i] = m_port[i];
      if (cyc == m_resp[i])  exp_rdata[i][m_port[i]] = m_rdat[i];
      if (!chk_en[i]) return;
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("m%0d_gnt", p), i, b(gnt[i][p]), b(cyc == m_issue[i] && m_port[i] == p[0]));
         chk($sformatf("m%0d_rvalid", p), i, b(rvalid[i][p]), b(cyc == m_resp[i] && m_port[i] == p[0]));
         chk($sformatf("m%0d_rdata", p), i, rdata[i][p], exp_rdata[i][p]);
      end
      chk("mem_r_enable", i, b(mem_r_enable[i]), b(cyc == m_issue[i] && !m_we[i]));
      chk("mem_w_enable", i, b(mem_w_enable[i]), b(cyc == m_issue[i] && m_we[i]));
      chk("busy", i, b(busy[i]), b(cyc >= m_busy_from[i] && cyc < m_free[i]));
      chk("owner", i, b(owner[i]), b(exp_owner[i]));
      if (cyc == m_issue[i]) begin
         chk("mem_addr", i, mem_addr[i], m_addr[i]);
         if (m_we[i]) chk("mem_wdata", i, mem_wdata[i], m_wdata[i]);
      end
      if (cyc == m_reset[i]) begin
         chk("mem_addr_rst", i, mem_addr[i], 32'd0);
         chk("mem_wdata_rst", i, mem_wdata[i], 32'd0);
      end
      if (in_cont) begin
         for (int p = 0; p < 2; p++) begin
            if (gnt[i][p] === 1'b1) begin
               n_cont[i]++;
               if (have_prev[i]) begin
                  chk("alt_port", i, b(p[0]), b(~prev_port[i]));
                  chk("alt_gap", i, cyc - prev_cyc[i], 32'd2);
               end
               have_prev[i] = 1'b1;
               prev_port[i] = p[0];
               prev_cyc[i]  = cyc;
            end
         end
      end
   endtask

   task automatic memory_side(input int i);
      logic [3:0] idx;
      idx = mem_addr[i][5:2];
      if (mem_w_enable[i] === 1'b1) rmem[i][idx] = mem_wdata[i];
      if (mem_r_enable[i] === 1'b1) begin
         ret_cyc[i] = cyc + lat_of(i);
         ret_dat[i] = rmem[i][idx];
      end
      mem_rdata[i] = (cyc == ret_cyc[i]) ? ret_dat[i] : $urandom;
   endtask

   task automatic drive_requesters(input int i);
      for (int p = 0; p < 2; p++) begin
         int k;
         k = i*2 + p;
         if (gprev[i][p] && active[i][p]) begin
            if (txq[k].size() > 0) txq[k].delete(0);
            active[i][p] = 1'b0;
         end
         gprev[i][p] = (gnt[i][p] === 1'b1);
         if (!active[i][p] && txq[k].size() > 0 && $urandom_range(99, 0) < rate) begin
            active[i][p] = 1'b1;
            we[i][p]     = txq[k][0].we;
            addr[i][p]   = txq[k][0].addr;
            wdata[i][p]  = txq[k][0].wdata;
         end else if (!active[i][p]) begin
            we[i][p]     = $urandom_range(1, 0) == 1;
            addr[i][p]   = $urandom;
            wdata[i][p]  = $urandom;
         end
         req[i][p] = active[i][p];
      end
   endtask

   task automatic drive_reset(input int i);
      if (rst_arm[i] && m_resp[i] >= 0 && cyc > m_issue[i] && cyc <= m_issue[i] + lat_of(i)) begin
         rst_cnt[i] = 1;
         rst_arm[i] = 1'b0;
      end
      if (rst_cnt[i] > 0) begin
         rst_cnt[i]--;
         reset_n[i]     = 1'b0;
         m_issue[i]     = -1;
         m_resp[i]      = -1;
         m_free[i]      = cyc + 1;
         m_busy_from[i] = cyc + 1;
         m_reset[i]     = cyc + 1;
         m_last[i]      = 1'b1;
      end else begin
         reset_n[i] = 1'b1;
      end
   endtask

   // A transaction sampled in cycle c issues at c+1; a read returns at c+lat+2 and frees the bus at c+lat+3.
   task automatic model_sample(input int i);
      logic       w;
      logic [3:0] idx;
      if (reset_n[i] && cyc >= m_free[i] && (req[i][0] || req[i][1])) begin
         w              = (req[i][0] && req[i][1]) ? ~m_last[i] : req[i][1];
         m_last[i]      = w;
         m_port[i]      = w;
         m_we[i]        = we[i][w];
         m_addr[i]      = addr[i][w];
         m_wdata[i]     = wdata[i][w];
         m_issue[i]     = cyc + 1;
         m_busy_from[i] = cyc + 1;
         idx            = addr[i][w][5:2];
         if (m_we[i]) begin
            mmem[i][idx] = m_wdata[i];
            m_resp[i]    = -1;
            m_free[i]    = cyc + 2;
         end else begin
            m_rdat[i] = mmem[i][idx];
            m_resp[i] = cyc + lat_of(i) + 2;
            m_free[i] = cyc + lat_of(i) + 3;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check_outputs(i);
         memory_side(i);
         drive_requesters(i);
         drive_reset(i);
         model_sample(i);
      end
      cyc++;
   endtask

   function automatic int outstanding();
      int n;
      n = 0;
      for (int i = 0; i < N; i++) begin
         if (cyc < m_free[i]) n++;
         for (int p = 0; p < 2; p++) begin
            n += txq[i*2+p].size();
            if (active[i][p]) n++;
         end
      end
      return n;
   endfunction

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (outstanding() != 0 && n < budget) begin
         step();
         n++;
      end
      chk("drain_outstanding", 0, outstanding(), 32'd0);
      repeat (2) step();
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < N; i++) rst_cnt[i] = n;
      repeat (n + 1) step();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         reset_n[i]      = 1'b0;
         mem_rdata[i]    = '0;
         ret_cyc[i]      = -1;
         ret_dat[i]      = '0;
         rst_cnt[i]      = 3;
         rst_arm[i]      = 1'b0;
         m_issue[i]      = -1;
         m_resp[i]       = -1;
         m_free[i]       = 0;
         m_busy_from[i]  = 0;
         m_reset[i]      = -1;
         m_last[i]       = 1'b1;
         m_port[i]       = 1'b0;
         m_we[i]         = 1'b0;
         m_addr[i]       = '0;
         m_wdata[i]      = '0;
         m_rdat[i]       = '0;
         exp_owner[i]    = 1'b0;
         chk_en[i]       = 1'b0;
         have_prev[i]    = 1'b0;
         prev_port[i]    = 1'b0;
         prev_cyc[i]     = 0;
         n_cont[i]       = 0;
         for (int p = 0; p < 2; p++) begin
            req[i][p]       = 1'b0;
            we[i][p]        = 1'b0;
            addr[i][p]      = '0;
            wdata[i][p]     = '0;
            active[i][p]    = 1'b0;
            gprev[i][p]     = 1'b0;
            exp_rdata[i][p] = '0;
         end
         for (int k = 0; k < 16; k++) begin
            rmem[i][k] = 32'hA500_0000 + 32'(k * 32'h0101);
            mmem[i][k] = 32'hA500_0000 + 32'(k * 32'h0101);
         end
      end
      repeat (5) step();

      // Lone read of 0x10 returning 0xDEADBEEF.
      for (int i = 0; i < N; i++) begin
         rmem[i][4] = 32'hDEAD_BEEF;
         mmem[i][4] = 32'hDEAD_BEEF;
         push(i, 0, 1'b0, 32'h10, 32'h0);
      end
      drain(100);

      // Tie straight after reset: port 0 read wins, port 1 write follows.
      do_reset(2);
      for (int i = 0; i < N; i++) begin
         push(i, 0, 1'b0, 32'h04, 32'h0);
         push(i, 1, 1'b1, 32'h20, 32'h55);
      end
      drain(100);

      // Continuous write contention: strict alternation, one issue every two cycles.
      in_cont = 1'b1;
      for (int i = 0; i < N; i++) begin
         have_prev[i] = 1'b0;
         n_cont[i]    = 0;
         for (int k = 0; k < 4; k++) begin
            push(i, 0, 1'b1, 32'(k * 4),      32'h100 + 32'(k));
            push(i, 1, 1'b1, 32'(32 + k * 4), 32'h200 + 32'(k));
         end
      end
      drain(200);
      in_cont = 1'b0;
      for (int i = 0; i < N; i++) chk("cont_grants", i, n_cont[i], 32'd8);

      // Port 1 read with data valid only in its return cycle.
      for (int i = 0; i < N; i++) begin
         rmem[i][12] = 32'h1234_5678;
         mmem[i][12] = 32'h1234_5678;
         push(i, 1, 1'b0, 32'h30, 32'h0);
      end
      drain(100);

      // Reset while a port 0 read waits, then a lone port 1 write, then a tie.
      for (int i = 0; i < N; i++) begin
         rst_arm[i] = 1'b1;
         push(i, 0, 1'b0, 32'h14, 32'h0);
      end
      drain(100);
      for (int i = 0; i < N; i++) push(i, 1, 1'b1, 32'h24, 32'h77);
      drain(100);
      for (int i = 0; i < N; i++) begin
         push(i, 0, 1'b1, 32'h28, 32'h88);
         push(i, 1, 1'b1, 32'h2C, 32'h99);
      end
      drain(100);

      // Back-to-back write then read-back of the same word from port 0.
      for (int i = 0; i < N; i++) begin
         push(i, 0, 1'b1, 32'h08, 32'hA5);
         push(i, 0, 1'b0, 32'h08, 32'h0);
      end
      drain(100);

      // Random mixed traffic.
      rate = 60;
      for (int r = 0; r < 60; r++) begin
         for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 2; p++) begin
               logic [3:0] ri;
               ri = 4'($urandom_range(15, 0));
               push(i, p, $urandom_range(1, 0) == 1, {26'd0, ri, 2'b00}, $urandom);
            end
         end
      end
      drain(20000);

      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < 16; k++) chk($sformatf("mem_word%0d", k), i, rmem[i][k], mmem[i][k]);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
